// File: rtl/cascade_mod_counter.sv
// Cascaded mod-N up/down counter chain with ripple carry/borrow, synchronous load,
// per-stage set-mode adjust, optional saturation and a registered chain-wrap pulse.
module cascade_mod_counter #(
  parameter int                  STAGES   = 3,
  parameter int                  W        = 6,
  parameter logic [STAGES*W-1:0] MODS     = {6'd24, 6'd60, 6'd60},
  parameter int                  SELW     = 2,
  parameter bit                  SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  up,
  input  logic                  load,
  input  logic [STAGES*W-1:0]   load_val,
  input  logic                  adj_en,
  input  logic [SELW-1:0]       adj_sel,
  output logic [STAGES*W-1:0]   count,
  output logic                  wrap,
  output logic                  at_max,
  output logic                  at_zero
);

  function automatic logic [W-1:0] stage_max(input int i);
    logic [W-1:0] m;
    m = MODS[i*W +: W];
    return m - W'(1);
  endfunction

  logic [W-1:0]          cur [STAGES];
  logic [STAGES:0]       carry_up;
  logic [STAGES:0]       carry_dn;
  logic [STAGES*W-1:0]   count_nxt;
  logic                  wrap_nxt;
  logic                  terminal;

  // Out-of-range stage values are pinned to the stage maximum before any
  // tick or adjust uses them, so a corrupted stage cannot spread.
  always_comb begin
    carry_up[0] = 1'b1;
    carry_dn[0] = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      cur[i] = (count[i*W +: W] > stage_max(i)) ? stage_max(i) : count[i*W +: W];
      carry_up[i+1] = carry_up[i] & (cur[i] == stage_max(i));
      carry_dn[i+1] = carry_dn[i] & (cur[i] == '0);
    end
    terminal = up ? carry_up[STAGES] : carry_dn[STAGES];
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (load) begin
      for (int i = 0; i < STAGES; i++) begin
        count_nxt[i*W +: W] = (load_val[i*W +: W] > stage_max(i)) ? stage_max(i)
                                                                   : load_val[i*W +: W];
      end
    end else if (adj_en) begin
      for (int i = 0; i < STAGES; i++) begin
        if (i == int'(adj_sel)) begin
          if (up) count_nxt[i*W +: W] = (cur[i] == stage_max(i)) ? '0 : cur[i] + W'(1);
          else    count_nxt[i*W +: W] = (cur[i] == '0) ? stage_max(i) : cur[i] - W'(1);
        end
      end
    end else if (tick) begin
      if (!(terminal && SATURATE)) begin
        wrap_nxt = terminal;
        for (int i = 0; i < STAGES; i++) begin
          if (up && carry_up[i])
            count_nxt[i*W +: W] = (cur[i] == stage_max(i)) ? '0 : cur[i] + W'(1);
          else if (!up && carry_dn[i])
            count_nxt[i*W +: W] = (cur[i] == '0) ? stage_max(i) : cur[i] - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    at_max  = 1'b1;
    at_zero = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      if (count[i*W +: W] != stage_max(i)) at_max  = 1'b0;
      if (count[i*W +: W] != '0)           at_zero = 1'b0;
    end
  end

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Directed bench for cascade_mod_counter: vector table on a wrapping 24/60/60 chain,
// plus hand sequences for saturation, back-to-back ticks and async reset.
module tb_cascade_mod_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, up, load, adj_en;
  logic [17:0] load_val;
  logic [1:0]  adj_sel;
  logic [17:0] count0, count1;
  logic        wrap0, wrap1, max0, max1, zero0, zero1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cascade_mod_counter #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .tick(tick), .up(up), .load(load), .load_val(load_val),
    .adj_en(adj_en), .adj_sel(adj_sel), .count(count0), .wrap(wrap0),
    .at_max(max0), .at_zero(zero0)
  );

  cascade_mod_counter #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .tick(tick), .up(up), .load(load), .load_val(load_val),
    .adj_en(adj_en), .adj_sel(adj_sel), .count(count1), .wrap(wrap1),
    .at_max(max1), .at_zero(zero1)
  );

  typedef struct {
    logic        ld;
    logic [17:0] lv;
    logic        adj;
    logic [1:0]  sel;
    logic        tk;
    logic        u;
    logic [17:0] ec;
    logic        ew;
    logic        emax;
    logic        ezero;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  function automatic vec_t mk(input logic ld, input logic [17:0] lv, input logic adj,
                              input logic [1:0] sel, input logic tk, input logic u,
                              input logic [17:0] ec, input logic ew,
                              input logic emax, input logic ezero);
    vec_t v;
    v.ld = ld; v.lv = lv; v.adj = adj; v.sel = sel; v.tk = tk; v.u = u;
    v.ec = ec; v.ew = ew; v.emax = emax; v.ezero = ezero;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [17:0] lv, input logic adj,
                       input logic [1:0] sel, input logic tk, input logic u);
    @(negedge clk);
    load = ld; load_val = lv; adj_en = adj; adj_sel = sel; tick = tk; up = u;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; load_val = '0; adj_en = 0; adj_sel = '0; tick = 0; up = 1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    check("reset_count", count0, 0);
    check("reset_wrap", wrap0, 0);
    check("reset_at_zero", zero0, 1);
    check("reset_at_max", max0, 0);
    @(negedge clk);
    reset = 1'b0;

    //           ld lv               adj sel tk up  exp count         w  max zero
    vecs.push_back(mk(1, hms(23,59,58), 0, 0, 0, 1, hms(23,59,58), 0, 0, 0));
    vecs.push_back(mk(0, '0,            0, 0, 1, 1, hms(23,59,59), 0, 1, 0));
    vecs.push_back(mk(0, '0,            0, 0, 1, 1, hms(0,0,0),    1, 0, 1));
    vecs.push_back(mk(0, '0,            0, 0, 0, 1, hms(0,0,0),    0, 0, 1));
    vecs.push_back(mk(0, '0,            0, 0, 1, 0, hms(23,59,59), 1, 1, 0));
    vecs.push_back(mk(0, '0,            0, 0, 1, 0, hms(23,59,58), 0, 0, 0));
    vecs.push_back(mk(1, hms(5,59,30),  0, 0, 0, 1, hms(5,59,30),  0, 0, 0));
    vecs.push_back(mk(0, '0,            1, 1, 0, 1, hms(5,0,30),   0, 0, 0));
    vecs.push_back(mk(0, '0,            1, 3, 0, 1, hms(5,0,30),   0, 0, 0));
    vecs.push_back(mk(0, '0,            1, 1, 0, 0, hms(5,59,30),  0, 0, 0));
    vecs.push_back(mk(0, '0,            1, 0, 0, 0, hms(5,59,29),  0, 0, 0));
    vecs.push_back(mk(0, '0,            1, 2, 0, 1, hms(6,59,29),  0, 0, 0));
    vecs.push_back(mk(1, 18'h3FFFF,     0, 0, 0, 1, hms(23,59,59), 0, 1, 0));
    vecs.push_back(mk(1, hms(1,2,3),    1, 2, 1, 1, hms(1,2,3),    0, 0, 0));
    vecs.push_back(mk(0, '0,            1, 2, 1, 1, hms(2,2,3),    0, 0, 0));
    vecs.push_back(mk(0, '0,            0, 0, 1, 1, hms(2,2,4),    0, 0, 0));
    vecs.push_back(mk(1, hms(0,59,59),  0, 0, 0, 1, hms(0,59,59),  0, 0, 0));
    vecs.push_back(mk(0, '0,            0, 0, 1, 1, hms(1,0,0),    0, 0, 0));
    vecs.push_back(mk(0, '0,            0, 0, 1, 0, hms(0,59,59),  0, 0, 0));
    vecs.push_back(mk(1, hms(0,0,0),    0, 0, 0, 1, hms(0,0,0),    0, 0, 1));
    vecs.push_back(mk(0, '0,            1, 2, 0, 0, hms(23,0,0),   0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].adj, vecs[i].sel, vecs[i].tk, vecs[i].u);
      check($sformatf("vec%0d_count", i), count0, vecs[i].ec);
      check($sformatf("vec%0d_wrap", i), wrap0, vecs[i].ew);
      check($sformatf("vec%0d_at_max", i), max0, vecs[i].emax);
      check($sformatf("vec%0d_at_zero", i), zero0, vecs[i].ezero);
    end

    // Saturation against wrapping, five back-to-back up ticks from all-max.
    drive(1, hms(23,59,59), 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      drive(0, '0, 0, 0, 1, 1);
      check($sformatf("sat_hold_count%0d", k), count1, hms(23,59,59));
      check($sformatf("sat_hold_wrap%0d", k), wrap1, 0);
      check($sformatf("b2b_count%0d", k), count0, (k == 1) ? hms(0,0,0) : hms(0,0,k-1));
      check($sformatf("b2b_wrap%0d", k), wrap0, (k == 1) ? 1 : 0);
    end
    drive(0, '0, 0, 0, 1, 0);
    check("sat_down_count", count1, hms(23,59,58));
    check("sat_down_wrap", wrap1, 0);
    drive(1, hms(0,0,0), 0, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0);
    check("sat_zero_hold", count1, hms(0,0,0));
    check("sat_zero_wrap", wrap1, 0);
    check("nosat_zero_wrap", wrap0, 1);

    // Asynchronous reset between edges while counting.
    drive(1, hms(12,34,56), 0, 0, 0, 1);
    drive(0, '0, 0, 0, 1, 1);
    check("pre_reset_count", count0, hms(12,34,57));
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check("async_reset_count", count0, 0);
    check("async_reset_zero", zero0, 1);
    @(negedge clk);
    reset = 1'b0;
    drive(0, '0, 0, 0, 1, 1);
    check("post_reset_tick", count0, hms(0,0,1));

    drive(1, hms(23,59,59), 0, 0, 0, 1);
    drive(0, '0, 0, 0, 1, 1);
    check("wrap_before_reset", wrap0, 1);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check("async_reset_wrap", wrap0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, '0, 0, 0, 1, 0);
    check("post_reset_down", count0, hms(23,59,59));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cascade_mod_counter.md
# cascade_mod_counter

Parametrised chain of STAGES mod-N up/down counters with ripple carry and borrow. Each stage has its own modulus. The block adds synchronous load, per-stage set-mode adjust without carry, optional saturation, and a chain-wrap pulse. It is the timekeeping and alarm-set core of the clock datapath: with the defaults it holds seconds, minutes and hours (60/60/24) and is driven by the 1 Hz tick and the set-mode buttons.

## Interface
- STAGES, 3, number of cascaded stages; stage 0 is least significant.
- W, 6, bits per stage.
- MODS, {6'd24,6'd60,6'd60}, packed STAGES*W moduli; stage i modulus is MODS[i*W +: W]; each must satisfy 2 <= MOD_i <= 2^W-1.
- SELW, 2, width of adj_sel; 2^SELW >= STAGES.
- SATURATE, 0, 1 = hold at all-max (up) or all-zero (down) instead of wrapping.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- tick  in  1  count enable, one-cycle pulse per count.
- up  in  1  direction for tick and adjust; 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  STAGES*W  packed load value, same layout as count.
- adj_en  in  1  set-mode single-stage step strobe.
- adj_sel  in  SELW  stage index to adjust.
- count  out  STAGES*W  packed stage values; stage i = count[i*W +: W].
- wrap  out  1  registered pulse: the chain wrapped on the last update.
- at_max  out  1  combinational: every stage = MOD_i-1.
- at_zero  out  1  combinational: every stage = 0.

## Operation
- Reset sets count = 0 and wrap = 0. at_zero is 1 and at_max is 0 during reset.
- Only one action is taken per cycle. Priority: load > adj_en > tick. A lower-priority strobe in the same cycle is dropped, not queued.
- Load:
  - Each stage takes its slice of load_val.
  - A slice >= MOD_i is clamped to MOD_i-1.
  - wrap = 0.
- Adjust:
  - Stage adj_sel steps by ±1 per up and wraps within its own modulus (MOD_i-1 ↔ 0).
  - No carry or borrow goes to other stages.
  - wrap = 0.
  - adj_sel >= STAGES is a no-op.
- Tick, counting up:
  - Stage i advances when tick = 1 and every stage j < i equals MOD_j-1. Stage 0 always advances.
  - An advancing stage at MOD_i-1 becomes 0; otherwise it increments.
- Tick, counting down:
  - Stage i advances when every stage j < i equals 0.
  - An advancing stage at 0 becomes MOD_i-1; otherwise it decrements.
- Chain wrap:
  - Occurs on tick up while at_max, or tick down while at_zero.
  - With SATURATE = 0: count goes to all-zero (up) or all-max (down), and wrap = 1 for one cycle.
  - With SATURATE = 1: count holds and wrap stays 0. Ticking away from the terminal works normally.
- No strobe: count holds and wrap = 0.
- Any out-of-range stage value (reachable only through a fault) is treated as MOD_i-1 by the next tick or adjust. It is never allowed to propagate.

## Timing
- All updates are on the posedge of clk. Latency is 1 cycle from strobe to new count.
- The full carry ripple resolves in one cycle: a single tick at the terminal updates every stage in the same edge.
- wrap is registered. It is high in the cycle in which count first shows the wrapped value, and low the next cycle unless another wrap occurs.
- Back-to-back ticks on consecutive cycles are supported, with each one counted.
- reset asserted mid-operation clears count and wrap immediately, without waiting for a clock edge. The first action after deassertion is taken on the first clock edge.

## Test plan
- Defaults, load 23:59:58 (load_val = {6'd23,6'd59,6'd58}), up = 1, two ticks → 23:59:59, then 00:00:00 with wrap = 1 for exactly one cycle; at_zero = 1.
- Defaults at 00:00:00, up = 0, tick → 23:59:59, wrap = 1, at_max = 1. A second tick → 23:59:58, wrap = 0.
- Adjust stage 1 = 59 at 05:59:30, up = 1 → 05:00:30 (no carry). With adj_sel = 3 → no change.
- Load {6'd63,6'd63,6'd63} → 23:59:59. load + adj_en + tick in the same cycle → loaded value only.
- SATURATE = 1, at_max, 5 up ticks → count held, wrap never asserts. One down tick → 23:59:58.
- reset pulse asynchronously between edges while counting at 12:34:56 → count = 0 and wrap = 0 immediately. Ticking resumes correctly after deassertion.
